pc_redirect_ctrl: RTL

Front-end sequencing controller for the pipelined RISC-V core. It resolves branch and jump outcomes from the EX stage (Zero/Neg flags, Jump and Branch codes) and produces the PC mux select. It also drives the PC and IF/ID write enables and the pipeline flush/hold signals, so load-use stalls, instruction-memory wait states and control redirects are applied in a fixed priority. It keeps saturating event counters for redirects and stall cycles.

---
 rtl/pc_redirect_ctrl_pkg.sv | 41 ++++
 rtl/pc_redirect_ctrl_sat_counter.sv | 48 ++++
 rtl/pc_redirect_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_ctrl_pkg
// Description : Shared constants for the front-end sequencing controller.
//               Covers the PC mux select codes, the EX-stage jump/branch codes
//               and the redirect FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_redirect_ctrl_pkg;

    // PC mux select
    localparam logic [1:0] PC_4       = 2'b00;
    localparam logic [1:0] PC_imm     = 2'b01;
    localparam logic [1:0] PC_reg_imm = 2'b10;

    // Jump codes from EX
    localparam logic [1:0] JumpNone = 2'b00;
    localparam logic [1:0] JumpJal  = 2'b01;
    localparam logic [1:0] JumpJalr = 2'b10;

    // Branch codes from EX
    localparam logic [2:0] B_type_none = 3'd0;
    localparam logic [2:0] B_type_beq  = 3'd1;
    localparam logic [2:0] B_type_bne  = 3'd2;
    localparam logic [2:0] B_type_blt  = 3'd3;
    localparam logic [2:0] B_type_bge  = 3'd4;

    // Redirect FSM
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // A conditional branch code takes the taken decision away from Jump.
    function automatic logic is_cond_branch(input logic [2:0] code);
        return (code == B_type_beq) || (code == B_type_bne) ||
               (code == B_type_blt) || (code == B_type_bge);
    endfunction

endpackage : pc_redirect_ctrl_pkg
`default_nettype wire

// File: rtl/pc_redirect_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at all-ones. A synchronous clear
//               wins over an increment in the same cycle.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset (count -> 0)
//               clr   - synchronous clear
//               inc   - count one event
//               q     - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + c_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_ctrl
// Description : Front-end sequencing controller. Resolves EX-stage branch and
//               jump outcomes into a PC mux select, and arbitrates redirects,
//               load-use stalls and instruction-fetch wait states into the
//               PC / IF/ID write enables and pipeline flush/hold controls.
//               Redirects that arrive while fetch is busy are parked in HOLD.
// Ports       : clk, rst_n                 - clock / async active-low reset
//               ex_valid, Zero, Neg        - EX stage valid and ALU flags
//               Jump[1:0], Branch[2:0]     - EX stage control codes
//               hz_stall                   - load-use stall request
//               imem_ready                 - fetch completes this cycle
//               cnt_clr                    - clear both event counters
//               pc_src[1:0], pc_we         - PC mux select / write enable
//               if_id_we, if_id_flush      - IF/ID write enable / bubble
//               id_ex_flush                - ID/EX bubble
//               ex_hold                    - freeze ID/EX and later stages
//               redirect_busy              - FSM is in HOLD
//               taken_cnt, stall_cnt       - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             Zero,
    input  logic             Neg,
    input  logic [1:0]       Jump,
    input  logic [2:0]       Branch,
    input  logic             hz_stall,
    input  logic             imem_ready,
    input  logic             cnt_clr,
    output logic [1:0]       pc_src,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_hold,
    output logic             redirect_busy,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e     state_d, state_q;
    logic [1:0] saved_src_d, saved_src_q;

    logic       w_hit;
    logic       w_taken;
    logic [1:0] w_tgt_src;
    logic       w_taken_inc;
    logic       w_stall_inc;

    // ------------------------------------------------------------------
    // Taken decode. A conditional branch code alone decides; otherwise
    // only JAL / JALR redirect.
    // ------------------------------------------------------------------
    always_comb begin
        w_hit     = 1'b0;
        w_tgt_src = PC_4;
        if (is_cond_branch(Branch)) begin
            w_tgt_src = PC_imm;
            case (Branch)
                B_type_beq: w_hit = Zero;
                B_type_bne: w_hit = !Zero;
                B_type_blt: w_hit = Neg;
                B_type_bge: w_hit = !Neg;
                default:    w_hit = 1'b0;
            endcase
        end else begin
            case (Jump)
                JumpJal: begin
                    w_hit     = 1'b1;
                    w_tgt_src = PC_imm;
                end
                JumpJalr: begin
                    w_hit     = 1'b1;
                    w_tgt_src = PC_reg_imm;
                end
                default: begin
                    w_hit     = 1'b0;
                    w_tgt_src = PC_4;
                end
            endcase
        end
        w_taken = ex_valid && w_hit;
    end

    // ------------------------------------------------------------------
    // Sequencing FSM: next state and pipeline controls.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        saved_src_d = saved_src_q;
        pc_src      = PC_4;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_hold     = 1'b0;
        w_taken_inc = 1'b0;
        w_stall_inc = 1'b0;

        case (state_q)
            RUN: begin
                if (w_taken) begin
                    pc_src = w_tgt_src;
                    if (imem_ready) begin
                        // Redirect now; any stall request belongs to a
                        // wrong-path instruction and is dropped.
                        pc_we       = 1'b1;
                        if_id_we    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        w_taken_inc = 1'b1;
                    end else begin
                        // Fetch busy: freeze everything and park the target.
                        ex_hold     = 1'b1;
                        saved_src_d = w_tgt_src;
                        state_d     = HOLD;
                    end
                end else if (hz_stall) begin
                    id_ex_flush = 1'b1;
                    w_stall_inc = 1'b1;
                end else begin
                    pc_we       = imem_ready;
                    if_id_we    = 1'b1;
                    // Fetch not done: IF/ID must take a bubble, not stale data.
                    if_id_flush = !imem_ready;
                end
            end

            HOLD: begin
                pc_src = saved_src_q;
                if (imem_ready) begin
                    pc_we       = 1'b1;
                    if_id_we    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    w_taken_inc = 1'b1;
                    state_d     = RUN;
                end else begin
                    ex_hold = 1'b1;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            saved_src_q <= PC_4;
        end else begin
            state_q     <= state_d;
            saved_src_q <= saved_src_d;
        end
    end

    assign redirect_busy = (state_q == HOLD);

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (w_taken_inc),
        .q     (taken_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (w_stall_inc),
        .q     (stall_cnt)
    );

endmodule : pc_redirect_ctrl
`default_nettype wire
